// File: rtl/logic_op_capture.sv
// rtl/logic_op_capture.sv - operand logic unit with debounced capture into a shift-register history
// The live result is registered every cycle; button presses snapshot it into the history.
module logic_op_capture #(
  parameter int WIDTH           = 4,
  parameter int DEPTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [2:0]                 sel,
  input  logic                       btn,
  input  logic                       clr,
  output logic [WIDTH-1:0]           y,
  output logic                       y_c,
  output logic [WIDTH*DEPTH-1:0]     hist,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       cap
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES+1);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES-1);
  localparam logic [CW-1:0] CMAX  = CW'(DEPTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r;
  logic             rc;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    r   = '0;
    rc  = 1'b0;
    case (sel)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~a;
      3'd4: r = ~(a & b);
      3'd5: r = ~(a | b);
      3'd6: r = ~(a ^ b);
      3'd7: begin
        r  = sum[WIDTH-1:0];
        rc = sum[WIDTH];
      end
      default: r = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y   <= '0;
      y_c <= 1'b0;
    end else begin
      y   <= r;
      y_c <= rc;
    end
  end

  logic          btn_m, btn_s, db, db_q;
  logic [DW-1:0] dcnt;
  logic          req;

  // Level changes are accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      db    <= 1'b0;
      db_q  <= 1'b0;
      dcnt  <= '0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
      db_q  <= db;
      if (btn_s == db) begin
        dcnt <= '0;
      end else if (dcnt == DLAST) begin
        db   <= btn_s;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end
  end

  assign req  = db & ~db_q;
  assign full = (count == CMAX);

  // clr takes priority; a press landing on the clear edge is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist  <= '0;
      count <= '0;
      cap   <= 1'b0;
    end else if (clr) begin
      hist  <= '0;
      count <= '0;
      cap   <= 1'b0;
    end else if (req) begin
      hist  <= {hist[WIDTH*(DEPTH-1)-1:0], r};
      count <= full ? count : count + CW'(1);
      cap   <= 1'b1;
    end else begin
      cap   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_op_capture.sv
// tb/tb_logic_op_capture.sv - self-checking bench for logic_op_capture
module tb_logic_op_capture;

  localparam int W = 4;
  localparam int D = 4;
  localparam int DB = 4;

  logic           clk, rst_n, btn, clr;
  logic [W-1:0]   a, b, y;
  logic [2:0]     sel;
  logic           y_c, full, cap;
  logic [W*D-1:0] hist;
  logic [2:0]     count;

  int checks = 0;
  int errors = 0;
  int edge_no;
  int cap_edges[$];
  int model_q[$];

  logic_op_capture #(.WIDTH(W), .DEPTH(D), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .btn(btn), .clr(clr),
    .y(y), .y_c(y_c), .hist(hist), .count(count), .full(full), .cap(cap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_r(input int av, input int bv, input int s);
    int m = (1 << W) - 1;
    case (s)
      0: return av & bv;
      1: return av | bv;
      2: return av ^ bv;
      3: return ~av & m;
      4: return ~(av & bv) & m;
      5: return ~(av | bv) & m;
      6: return ~(av ^ bv) & m;
      default: return (av + bv) % (1 << W);
    endcase
  endfunction

  function automatic int ref_c(input int av, input int bv, input int s);
    return (s == 7 && (av + bv) >= (1 << W)) ? 1 : 0;
  endfunction

  function automatic logic [W*D-1:0] exp_hist();
    logic [W*D-1:0] v = '0;
    for (int k = 0; k < model_q.size(); k++) v[k*W +: W] = W'(model_q[k]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input int v);
    model_q.push_front(v);
    if (model_q.size() > D) void'(model_q.pop_back());
  endtask

  task automatic check_hist(input string tag);
    chk({tag, "_hist"}, 32'(hist), 32'(exp_hist()));
    chk({tag, "_count"}, 32'(count), 32'(model_q.size()));
    chk({tag, "_full"}, 32'(full), 32'(model_q.size() == D));
  endtask

  // Steps n edges with btn/clr held, logging which edges were followed by a cap pulse.
  task automatic play(input logic lv, input int n, input logic c);
    for (int i = 0; i < n; i++) begin
      btn = lv;
      clr = c;
      @(posedge clk);
      @(negedge clk);
      if (cap) cap_edges.push_back(edge_no);
      edge_no++;
    end
    clr = 1'b0;
  endtask

  task automatic start_window();
    edge_no = 0;
    cap_edges.delete();
  endtask

  task automatic check_one_cap(input string tag, input int exp_edge);
    chk({tag, "_ncap"}, 32'(cap_edges.size()), 32'd1);
    chk({tag, "_edge"}, (cap_edges.size() == 1) ? 32'(cap_edges[0]) : 32'hffff_ffff, 32'(exp_edge));
  endtask

  task automatic press_once(input string tag, input int av, input int bv, input int s, input int hold);
    a = W'(av); b = W'(bv); sel = 3'(s);
    play(1'b0, 12, 1'b0);
    start_window();
    play(1'b1, hold, 1'b0);
    check_one_cap(tag, 2 + DB);
    model_push(ref_r(av, bv, s));
    check_hist(tag);
  endtask

  initial begin
    logic [W-1:0] sweep_exp [8];
    int av, bv, s;
    sweep_exp = '{4'h8, 4'hE, 4'h6, 4'h3, 4'h7, 4'h1, 4'h9, 4'h6};
    rst_n = 1'b0; btn = 1'b0; clr = 1'b0; a = '0; b = '0; sel = '0;
    @(negedge clk);
    chk("rst_y", 32'(y), 0);
    chk("rst_yc", 32'(y_c), 0);
    chk("rst_hist", 32'(hist), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_cap", 32'(cap), 0);
    rst_n = 1'b1;

    a = 4'hC; b = 4'hA;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      @(posedge clk); @(negedge clk);
      chk($sformatf("sweep_y%0d", i), 32'(y), 32'(sweep_exp[i]));
      chk($sformatf("sweep_yc%0d", i), 32'(y_c), (i == 7) ? 32'd1 : 32'd0);
    end

    for (int i = 0; i < 24; i++) begin
      av = int'($urandom_range(0, (1 << W) - 1));
      bv = int'($urandom_range(0, (1 << W) - 1));
      s  = int'($urandom_range(0, 7));
      a = W'(av); b = W'(bv); sel = 3'(s);
      @(posedge clk); @(negedge clk);
      chk("rand_y", 32'(y), 32'(ref_r(av, bv, s)));
      chk("rand_yc", 32'(y_c), 32'(ref_c(av, bv, s)));
    end

    press_once("press", 3, 5, 7, 20);

    a = 4'h6; b = 4'h3; sel = 3'd2;
    play(1'b0, 12, 1'b0);
    start_window();
    play(1'b1, 3, 1'b0);
    play(1'b0, 2, 1'b0);
    play(1'b1, 2, 1'b0);
    play(1'b0, 1, 1'b0);
    play(1'b1, 20, 1'b0);
    check_one_cap("bounce", 8 + 2 + DB);
    model_push(ref_r(6, 3, 2));
    check_hist("bounce");

    play(1'b0, 2, 1'b1);
    model_q.delete();
    check_hist("clr");
    for (int v = 1; v <= 5; v++) press_once($sformatf("fill%0d", v), v, 0, 1, 10);
    chk("fill_hist", 32'(hist), 32'h2345);

    for (int i = 0; i < 3; i++)
      press_once("rpress", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 7)), 10);

    play(1'b0, 1, 1'b1);
    model_q.delete();
    press_once("pre_col1", 9, 4, 0, 10);
    press_once("pre_col2", 9, 4, 7, 10);
    play(1'b0, 12, 1'b0);
    start_window();
    play(1'b1, 2 + DB, 1'b0);
    play(1'b1, 1, 1'b1);
    play(1'b1, 8, 1'b0);
    chk("col_ncap", 32'(cap_edges.size()), 0);
    model_q.delete();
    check_hist("col");
    press_once("post_col", 12, 10, 4, 10);

    a = 4'hC; b = 4'hA; sel = 3'd7;
    play(1'b0, 12, 1'b0);
    play(1'b1, 3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y", 32'(y), 0);
    chk("arst_hist", 32'(hist), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_full", 32'(full), 0);
    chk("arst_cap", 32'(cap), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_q.delete();
    start_window();
    play(1'b1, 12, 1'b0);
    check_one_cap("rst_press", 2 + DB);
    model_push(ref_r(12, 10, 7));
    check_hist("rst_press");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_op_capture.md
# logic_op_capture

Parametrised operand-logic unit with a debounced capture button and a shift-register history. Each cycle it computes one of eight bitwise/arithmetic operations on two WIDTH-bit operands. On every debounced button press it pushes the current result into a DEPTH-entry history. It sits between board switches/buttons and LED/display drivers in the basic-gate demo designs, and generalises the earlier fixed 1-bit, 4-op, 2-stage capture block.

## Interface
- WIDTH, 4, operand/result width in bits (>=1)
- DEPTH, 4, history entries (>=2)
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to accept a button level change (>=1)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sel  in  3  operation select
- btn  in  1  raw asynchronous push button, active high
- clr  in  1  synchronous history clear, active high
- y  out  WIDTH  registered live result
- y_c  out  1  registered carry of op 7, 0 for other ops
- hist  out  WIDTH*DEPTH  history, entry k at bits [k*WIDTH +: WIDTH], entry 0 newest
- count  out  $clog2(DEPTH+1)  number of valid history entries
- full  out  1  count == DEPTH
- cap  out  1  one-cycle pulse: a capture was accepted at the previous edge

## Operation
- Result r(a,b,sel): 0 a&b; 1 a|b; 2 a^b; 3 ~a; 4 ~(a&b); 5 ~(a|b); 6 ~(a^b); 7 a+b mod 2^WIDTH, with carry = bit WIDTH of the (WIDTH+1)-bit sum.
- y/y_c register r and carry every cycle, independent of the button.
- Button path: 2-flop synchroniser (btn_s), then debouncer holding level db and counter dcnt.
  - btn_s == db: dcnt <= 0.
  - btn_s != db and dcnt < DEBOUNCE_CYCLES-1: dcnt <= dcnt+1.
  - btn_s != db and dcnt == DEBOUNCE_CYCLES-1: db <= btn_s, dcnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised samples never changes db.
- Press detect: db_q registers db; capture request = db & ~db_q (rising edge only; releases are ignored).
- Capture (request and not clr): hist[0] <= r of the current cycle (the same value y loads at that edge); hist[k] <= hist[k-1] for k=1..DEPTH-1; oldest entry discarded; count <= min(count+1, DEPTH); cap <= 1.
- clr: hist <= 0, count <= 0, cap <= 0. clr wins over a simultaneous capture; that press is lost, not deferred.
- Otherwise hist/count hold and cap <= 0.
- Full: further captures keep shifting (oldest lost); count stays DEPTH and full stays 1.

## Timing
- Reset (rst_n low, asynchronous): y=0, y_c=0, hist=0, count=0, full=0, cap=0; synchroniser flops, db, db_q and dcnt all 0. Release is synchronous to the next edge.
- y latency: 1 cycle from a/b/sel change.
- Press latency: let edge 0 be the first edge sampling btn=1, held stable. btn_s=1 after edge 1. db=1 after edge 1+DEBOUNCE_CYCLES. The capture edge is E = 2+DEBOUNCE_CYCLES. hist, count and cap update at E, and cap is high for exactly the cycle after E. Default: E = 6.
- One capture per press regardless of hold length. Next capture requires db to fall (release stable for DEBOUNCE_CYCLES samples), then rise again.
- Reset mid-debounce aborts the pending press. If btn is still held after reset release, it is treated as a new press: capture at E counted from the first post-reset edge.
- full is combinational from count (no extra latency).

## Test plan
- Reset: assert rst_n=0 mid-cycle with nonzero hist -> all outputs 0 immediately (asynchronously), count=0.
- Ops sweep, WIDTH=4, a=4'hC, b=4'hA, sel 0..7 -> y = 8,E,6,3,7,1,9,6; at sel=7, y_c=1.
- Press timing: a=3,b=5,sel=7, btn rises and holds 20 cycles -> single cap pulse at edge 6, hist[0]=8, count=1, no second capture while held.
- Bounce: btn pulses high 3 cycles, low 2, high 2, then stable high -> exactly one capture, 6 edges after the start of the final stable high.
- Fill/overflow, DEPTH=4: 5 presses with results 1,2,3,4,5 -> hist entries 0..3 = 5,4,3,2; count=4, full=1.
- clr collision: assert clr on capture edge E with count=2 -> hist=0, count=0, cap stays 0; the next press captures normally with count=1.
